// File: rtl/vsfx_pkg.sv
// Shared encodings, control payload and decode helpers for the pipelined
// vector simple fixed-point unit.
package vsfx_pkg;

  localparam int unsigned LANE_W = 32;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ESZ_W  = 2;
  localparam int unsigned CR6_W  = 4;

  localparam logic [OP_W-1:0] OP_ADDM   = 4'd0;
  localparam logic [OP_W-1:0] OP_ADDSS  = 4'd1;
  localparam logic [OP_W-1:0] OP_ADDUS  = 4'd2;
  localparam logic [OP_W-1:0] OP_SUBM   = 4'd3;
  localparam logic [OP_W-1:0] OP_SUBSS  = 4'd4;
  localparam logic [OP_W-1:0] OP_CMPEQ  = 4'd5;
  localparam logic [OP_W-1:0] OP_CMPGTS = 4'd6;
  localparam logic [OP_W-1:0] OP_AVGS   = 4'd7;
  localparam logic [OP_W-1:0] OP_SL     = 4'd8;

  localparam logic [ESZ_W-1:0] ESZ_BYTE = 2'd0;
  localparam logic [ESZ_W-1:0] ESZ_HALF = 2'd1;
  localparam logic [ESZ_W-1:0] ESZ_WORD = 2'd2;
  localparam logic [ESZ_W-1:0] ESZ_RSVD = 2'd3;

  // cr6 = {all_true, 0, all_false, 0}
  localparam int unsigned CR6_ALL_TRUE_BIT  = 3;
  localparam int unsigned CR6_ALL_FALSE_BIT = 1;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ESZ_W-1:0] esz;
    logic             rc;
  } vsfx_ctrl_t;

  function automatic logic is_reserved(input logic [OP_W-1:0] op, input logic [ESZ_W-1:0] esz);
    return (op > OP_SL) || (esz == ESZ_RSVD);
  endfunction

  function automatic logic is_cmp(input logic [OP_W-1:0] op);
    return (op == OP_CMPEQ) || (op == OP_CMPGTS);
  endfunction

endpackage

// File: rtl/vsfx_if.sv
// Issue/result bus between the register-file read port, the unit and the
// writeback arbiter.
interface vsfx_if #(
  parameter int unsigned VLEN = 128
);
  import vsfx_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   op;
  logic [ESZ_W-1:0]  esz;
  logic              rc;
  logic [VLEN-1:0]   vra;
  logic [VLEN-1:0]   vrb;
  logic              clr_sat;
  logic              out_valid;
  logic              out_ready;
  logic [VLEN-1:0]   vrt;
  logic              sat;
  logic [CR6_W-1:0]  cr6;

  modport master (
    output in_valid, op, esz, rc, vra, vrb, clr_sat, out_ready,
    input  in_ready, out_valid, vrt, sat, cr6
  );

  modport slave (
    input  in_valid, op, esz, rc, vra, vrb, clr_sat, out_ready,
    output in_ready, out_valid, vrt, sat, cr6
  );

endinterface

// File: rtl/vsfx_lane.sv
// One 32-bit lane: every op at every element size in parallel, then a select
// by esz. Purely combinational.
module vsfx_lane
  import vsfx_pkg::*;
(
  input  logic [OP_W-1:0]   op,
  input  logic [ESZ_W-1:0]  esz,
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] result,
  output logic              sat,
  output logic              any_true,
  output logic              any_false
);

  localparam int unsigned N_SZ = 3;

  logic [N_SZ-1:0][LANE_W-1:0] res_sz;
  logic [N_SZ-1:0]             sat_sz;
  logic [N_SZ-1:0]             true_sz;
  logic [N_SZ-1:0]             false_sz;

  for (genvar s = 0; s < N_SZ; s++) begin : g_sz
    localparam int unsigned EW  = 8 << s;
    localparam int unsigned NE  = LANE_W / EW;
    localparam int unsigned SHW = $clog2(EW);

    logic [NE-1:0][EW-1:0] res_e;
    logic [NE-1:0]         sat_e;
    logic [NE-1:0]         true_e;

    for (genvar e = 0; e < NE; e++) begin : g_el
      logic [EW-1:0]        ea, eb, er;
      logic signed [EW:0]   sa, sb, ssum, sdif, avg;
      logic [EW:0]          usum;
      logic                 cmp, es, tr;

      // One guard bit holds every sum/difference/average without loss
      assign ea   = a[e*EW +: EW];
      assign eb   = b[e*EW +: EW];
      assign sa   = {ea[EW-1], ea};
      assign sb   = {eb[EW-1], eb};
      assign ssum = sa + sb;
      assign sdif = sa - sb;
      assign avg  = ssum + (EW+1)'(1);
      assign usum = {1'b0, ea} + {1'b0, eb};
      assign cmp  = (op == OP_CMPEQ) ? (ea == eb) : (sa > sb);

      always_comb begin
        er = '0;
        es = 1'b0;
        tr = 1'b0;
        case (op)
          OP_ADDM: er = ssum[EW-1:0];
          OP_ADDSS: begin
            er = ssum[EW-1:0];
            if (ssum[EW] != ssum[EW-1]) begin
              er = {ssum[EW], {(EW-1){~ssum[EW]}}};
              es = 1'b1;
            end
          end
          OP_ADDUS: begin
            er = usum[EW-1:0];
            if (usum[EW]) begin
              er = '1;
              es = 1'b1;
            end
          end
          OP_SUBM: er = sdif[EW-1:0];
          OP_SUBSS: begin
            er = sdif[EW-1:0];
            if (sdif[EW] != sdif[EW-1]) begin
              er = {sdif[EW], {(EW-1){~sdif[EW]}}};
              es = 1'b1;
            end
          end
          OP_CMPEQ, OP_CMPGTS: begin
            er = {EW{cmp}};
            tr = cmp;
          end
          OP_AVGS: er = EW'(avg >>> 1);
          OP_SL:   er = ea << eb[SHW-1:0];
          default: er = '0;
        endcase
      end

      assign res_e[e]  = er;
      assign sat_e[e]  = es;
      assign true_e[e] = tr;
    end

    assign res_sz[s]   = res_e;
    assign sat_sz[s]   = |sat_e;
    assign true_sz[s]  = |true_e;
    assign false_sz[s] = ~&true_e;
  end

  always_comb begin
    result    = '0;
    sat       = 1'b0;
    any_true  = 1'b0;
    any_false = 1'b0;
    if (!is_reserved(op, esz)) begin
      result    = res_sz[esz];
      sat       = sat_sz[esz];
      any_true  = true_sz[esz];
      any_false = false_sz[esz];
    end
  end

endmodule

// File: rtl/vsfx_pipe.sv
// Two-stage vector simple fixed-point unit: lane datapath into S1, output
// register S2, with sticky SAT and record-form CR6 tracking.
module vsfx_pipe
  import vsfx_pkg::*;
#(
  parameter int unsigned VLEN = 128
) (
  input  logic  clk,
  input  logic  rst_n,
  vsfx_if.slave bus
);

  localparam int unsigned LANES = VLEN / LANE_W;

  logic [VLEN-1:0]  lane_res;
  logic [LANES-1:0] lane_sat, lane_true, lane_false;

  logic             s1_valid;
  vsfx_ctrl_t       s1_ctrl;
  logic [VLEN-1:0]  s1_res;
  logic [LANES-1:0] s1_sat, s1_true, s1_false;

  logic             out_valid_q;
  logic [VLEN-1:0]  vrt_q;
  logic             sat_q;
  logic [CR6_W-1:0] cr6_q;

  logic             stall_c;
  logic             s1_move_c;
  logic             cr6_upd_c;
  logic [CR6_W-1:0] cr6_new_c;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vsfx_lane u_lane (
      .op        (bus.op),
      .esz       (bus.esz),
      .a         (bus.vra[i*LANE_W +: LANE_W]),
      .b         (bus.vrb[i*LANE_W +: LANE_W]),
      .result    (lane_res[i*LANE_W +: LANE_W]),
      .sat       (lane_sat[i]),
      .any_true  (lane_true[i]),
      .any_false (lane_false[i])
    );
  end

  assign stall_c   = out_valid_q & ~bus.out_ready;
  assign s1_move_c = s1_valid & ~stall_c;
  assign cr6_upd_c = s1_move_c & s1_ctrl.rc & is_cmp(s1_ctrl.op)
                   & ~is_reserved(s1_ctrl.op, s1_ctrl.esz);

  always_comb begin
    cr6_new_c                    = '0;
    cr6_new_c[CR6_ALL_TRUE_BIT]  = ~|s1_false;
    cr6_new_c[CR6_ALL_FALSE_BIT] = ~|s1_true;
  end

  // S1: control and per-lane results/flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_res   <= '0;
      s1_sat   <= '0;
      s1_true  <= '0;
      s1_false <= '0;
    end else if (!stall_c) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_ctrl  <= '{op: bus.op, esz: bus.esz, rc: bus.rc};
        s1_res   <= lane_res;
        s1_sat   <= lane_sat;
        s1_true  <= lane_true;
        s1_false <= lane_false;
      end
    end
  end

  // S2: output register; bubbles leave vrt untouched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      vrt_q       <= '0;
    end else if (!stall_c) begin
      out_valid_q <= s1_valid;
      if (s1_valid) vrt_q <= s1_res;
    end
  end

  // A landing op's saturation beats a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= 1'b0;
    end else if (s1_move_c && (|s1_sat)) begin
      sat_q <= 1'b1;
    end else if (bus.clr_sat) begin
      sat_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr6_q <= '0;
    end else if (cr6_upd_c) begin
      cr6_q <= cr6_new_c;
    end
  end

  assign bus.in_ready  = ~stall_c;
  assign bus.out_valid = out_valid_q;
  assign bus.vrt       = vrt_q;
  assign bus.sat       = sat_q;
  assign bus.cr6       = cr6_q;

endmodule

// File: tb/tb_vsfx_pipe.sv
// Scoreboard bench for vsfx_pipe: an element-level integer model predicts each
// result, sticky sat and cr6; a monitor compares them as results are consumed.
module tb_vsfx_pipe;
  import vsfx_pkg::*;

  localparam int unsigned VLEN = 128;
  localparam int          TMO  = 200;

  typedef struct {
    logic [VLEN-1:0]  vrt;
    logic             sat;
    logic [CR6_W-1:0] cr6;
    int               acc;
    bit               lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  int               cyc = 0;
  int               n_checks = 0;
  int               n_errors = 0;
  int               n_out = 0;
  int               out_base;
  logic             model_sat;
  logic [CR6_W-1:0] model_cr6;
  bit               lat_en;
  exp_t             sb_q[$];
  exp_t             mon_e;
  logic [VLEN-1:0]  ra, rb;

  vsfx_if #(.VLEN(VLEN)) bus ();

  vsfx_pipe #(.VLEN(VLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [VLEN-1:0] got, input logic [VLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [OP_W-1:0] op, input logic [ESZ_W-1:0] esz,
                                input logic [VLEN-1:0] a, input logic [VLEN-1:0] b,
                                output logic [VLEN-1:0] r, output logic s,
                                output logic all_t, output logic all_f);
    int     ew, ne;
    longint mask, hi, lo;
    r = '0; s = 1'b0; all_t = 1'b1; all_f = 1'b1;
    if (op > 4'd8 || esz == 2'd3) return;
    ew   = 8 << esz;
    ne   = VLEN / ew;
    mask = (longint'(1) << ew) - 1;
    hi   = (longint'(1) << (ew - 1)) - 1;
    lo   = -hi - 1;
    for (int e = 0; e < ne; e++) begin
      logic [VLEN-1:0] ta, tb;
      longint ua, ub, sa, sb, v;
      bit t;
      ta = a >> (e * ew);
      tb = b >> (e * ew);
      ua = longint'(ta[31:0]) & mask;
      ub = longint'(tb[31:0]) & mask;
      sa = (ua > hi) ? ua - (mask + 1) : ua;
      sb = (ub > hi) ? ub - (mask + 1) : ub;
      t  = 1'b0;
      v  = 0;
      case (op)
        OP_ADDM: v = ua + ub;
        OP_ADDSS: begin
          v = sa + sb;
          if (v > hi) begin v = hi; s = 1'b1; end
          else if (v < lo) begin v = lo; s = 1'b1; end
        end
        OP_ADDUS: begin
          v = ua + ub;
          if (v > mask) begin v = mask; s = 1'b1; end
        end
        OP_SUBM: v = ua - ub;
        OP_SUBSS: begin
          v = sa - sb;
          if (v > hi) begin v = hi; s = 1'b1; end
          else if (v < lo) begin v = lo; s = 1'b1; end
        end
        OP_CMPEQ:  begin t = (ua == ub); v = t ? mask : 0; end
        OP_CMPGTS: begin t = (sa > sb);  v = t ? mask : 0; end
        OP_AVGS:   v = (sa + sb + 1) >>> 1;
        OP_SL:     v = ua << (ub % ew);
        default:   v = 0;
      endcase
      r = r | (VLEN'(v & mask) << (e * ew));
      if (op == OP_CMPEQ || op == OP_CMPGTS) begin
        all_t = all_t & t;
        all_f = all_f & ~t;
      end
    end
  endfunction

  // Called at a negedge; returns at the negedge after the op is accepted
  task automatic issue(input logic [OP_W-1:0] op, input logic [ESZ_W-1:0] esz, input logic rc,
                       input logic [VLEN-1:0] a, input logic [VLEN-1:0] b);
    logic [VLEN-1:0] r;
    logic s, at, af;
    exp_t e;
    int n;
    bus.in_valid = 1'b1;
    bus.op  = op;
    bus.esz = esz;
    bus.rc  = rc;
    bus.vra = a;
    bus.vrb = b;
    model(op, esz, a, b, r, s, at, af);
    #1;
    n = 0;
    while (!bus.in_ready && n < TMO) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", VLEN'(bus.in_ready), VLEN'(1));
    end else begin
      model_sat = model_sat | s;
      if (rc && (op == OP_CMPEQ || op == OP_CMPGTS) && esz != 2'd3)
        model_cr6 = {at, 1'b0, af, 1'b0};
      e.vrt = r;
      e.sat = model_sat;
      e.cr6 = model_cr6;
      e.acc = cyc;
      e.lat = lat_en;
      sb_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid = 1'b0;
    while (sb_q.size() != 0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      check("drain_timeout", VLEN'(sb_q.size()), '0);
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    bus.clr_sat = 1'b1;
    @(negedge clk);
    bus.clr_sat = 1'b0;
    model_sat = 1'b0;
    #1 check("sat_clear", VLEN'(bus.sat), VLEN'(model_sat));
  endtask

  // Monitor: a result is consumed at the next posedge when valid & ready
  always @(negedge clk) begin
    #2;
    if (rst_n && bus.out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_out", VLEN'(bus.out_valid), '0);
      end else begin
        mon_e = sb_q[0];
        if (!bus.out_ready) begin
          check("stall_in_ready", VLEN'(bus.in_ready), '0);
          check("stall_vrt", bus.vrt, mon_e.vrt);
        end else begin
          check("vrt", bus.vrt, mon_e.vrt);
          check("sat", VLEN'(bus.sat), VLEN'(mon_e.sat));
          check("cr6", VLEN'(bus.cr6), VLEN'(mon_e.cr6));
          if (mon_e.lat) check("latency", VLEN'(cyc - mon_e.acc), VLEN'(2));
          void'(sb_q.pop_front());
          n_out++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.op = '0; bus.esz = '0; bus.rc = 1'b0;
    bus.vra = '0; bus.vrb = '0; bus.clr_sat = 1'b0; bus.out_ready = 1'b1;
    model_sat = 1'b0; model_cr6 = '0; lat_en = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", VLEN'(bus.out_valid), '0);
    check("rst_vrt", bus.vrt, '0);
    check("rst_sat", VLEN'(bus.sat), '0);
    check("rst_cr6", VLEN'(bus.cr6), '0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", VLEN'(bus.in_ready), VLEN'(1));
    @(negedge clk);

    // Word signed saturation, then explicit clear
    issue(OP_ADDSS, ESZ_WORD, 1'b0, {(VLEN/32){32'h7FFF_FFFF}}, {(VLEN/32){32'h0000_0001}});
    drain();
    pulse_clr();

    // Byte modulo vs unsigned saturating add
    issue(OP_ADDM,  ESZ_BYTE, 1'b0, {(VLEN/8){8'hFF}}, {(VLEN/8){8'h01}});
    drain();
    issue(OP_ADDUS, ESZ_BYTE, 1'b0, {(VLEN/8){8'hFF}}, {(VLEN/8){8'h01}});
    drain();
    pulse_clr();

    // Record-form compares: all true, all false, mixed
    issue(OP_CMPEQ, ESZ_HALF, 1'b1, {(VLEN/16){16'h1234}}, {(VLEN/16){16'h1234}});
    issue(OP_CMPEQ, ESZ_HALF, 1'b1, {(VLEN/16){16'h1234}}, {(VLEN/16){16'h0000}});
    issue(OP_CMPEQ, ESZ_HALF, 1'b1, {(VLEN/16){16'h1234}}, VLEN'(16'h1234));
    issue(OP_CMPGTS, ESZ_WORD, 1'b0, {(VLEN/32){32'h0000_0001}}, {(VLEN/32){32'hFFFF_FFFF}});
    drain();

    // Average and shift
    issue(OP_AVGS, ESZ_HALF, 1'b0, {(VLEN/16){16'h8000}}, {(VLEN/16){16'hFFFF}});
    issue(OP_SL,   ESZ_BYTE, 1'b0, {(VLEN/8){8'h81}},     {(VLEN/8){8'h09}});
    issue(OP_SUBSS, ESZ_BYTE, 1'b0, {(VLEN/8){8'h80}},    {(VLEN/8){8'h01}});
    issue(4'd9,    ESZ_WORD, 1'b1, {(VLEN/32){32'h1234_5678}}, {(VLEN/32){32'h1}});
    issue(OP_CMPEQ, ESZ_RSVD, 1'b1, '0, '0);
    drain();

    // Back-pressure: four back-to-back ops, consumer stalls three cycles
    lat_en = 1'b0;
    out_base = n_out;
    fork
      begin
        for (int i = 0; i < 4; i++)
          issue(OP_ADDM, ESZ_WORD, 1'b0, {(VLEN/32){32'(i * 16 + 1)}}, {(VLEN/32){32'h100}});
        bus.in_valid = 1'b0;
      end
      begin
        for (int n = 0; n < TMO && !bus.out_valid; n++) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();
    check("bp_delivered", VLEN'(n_out - out_base), VLEN'(4));
    lat_en = 1'b1;

    // Random mix including reserved codes
    for (int i = 0; i < 24; i++) begin
      ra = VLEN'({$urandom, $urandom, $urandom, $urandom});
      rb = VLEN'({$urandom, $urandom, $urandom, $urandom});
      if (i % 3 == 0) rb = ra;
      issue(4'($urandom_range(0, 10)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rb);
    end
    drain();

    // Set sat and cr6, then reset with two ops in flight
    issue(OP_CMPEQ, ESZ_WORD, 1'b1, '1, '1);
    issue(OP_ADDUS, ESZ_BYTE, 1'b0, {(VLEN/8){8'hFF}}, {(VLEN/8){8'h01}});
    drain();
    issue(OP_ADDM, ESZ_WORD, 1'b0, {(VLEN/32){32'h5}}, {(VLEN/32){32'h6}});
    issue(OP_SUBM, ESZ_WORD, 1'b0, {(VLEN/32){32'h5}}, {(VLEN/32){32'h6}});
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", VLEN'(bus.out_valid), '0);
    check("rst_mid_sat", VLEN'(bus.sat), '0);
    check("rst_mid_cr6", VLEN'(bus.cr6), '0);
    sb_q.delete();
    model_sat = 1'b0;
    model_cr6 = '0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("post_rst_out_valid", VLEN'(bus.out_valid), '0);
    check("post_rst_in_ready", VLEN'(bus.in_ready), VLEN'(1));
    @(negedge clk);
    issue(OP_ADDM, ESZ_HALF, 1'b0, {(VLEN/16){16'h7FFF}}, {(VLEN/16){16'h0002}});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vsfx_pipe.md
Name: vsfx_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle vector simple fixed-point unit.
- Performs per-element integer operations on two VLEN-bit vector operands.
- Element size is selectable per instruction: byte, halfword or word.
- Uses a two-stage pipeline with valid/ready handshakes on both sides, a sticky SAT bit with explicit clear, and CR6 generation for record-form compares.
- Sits between the vector register file read port and the writeback arbiter.

Parameters:
- VLEN, 128, vector width in bits; must be a multiple of 32.
- LANES, VLEN/32, number of 32-bit lanes (derived; not overridable).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit accepts operation this cycle.
- op  input  4  operation code (see Behaviour).
- esz  input  2  element size: 0 byte, 1 half, 2 word; 3 is reserved.
- rc  input  1  record form: update cr6 (compare only).
- vra  input  VLEN  operand A.
- vrb  input  VLEN  operand B.
- clr_sat  input  1  synchronous clear of sticky sat.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- vrt  output  VLEN  result vector.
- sat  output  1  sticky saturation bit (VSCR[SAT]).
- cr6  output  4  condition field 6, {all_true, 0, all_false, 0}.

Behaviour:
- Interface fixed: one clock; reset is asynchronous and active-low.
- Reset values: out_valid=0, vrt=0, sat=0, cr6=0. Internal stage valids are cleared. in_ready=1 once reset is released.
- Op codes:
  - 0 ADDM: add modulo.
  - 1 ADDSS: add, signed saturate.
  - 2 ADDUS: add, unsigned saturate.
  - 3 SUBM: subtract modulo, A-B.
  - 4 SUBSS: subtract, signed saturate.
  - 5 CMPEQ: compare equal.
  - 6 CMPGTS: compare greater-than, signed.
  - 7 AVGS: signed average.
  - 8 SL: shift left.
  - 9-15: reserved.
- Element rules:
  - Compare: result element is all-ones if true, else zero.
  - AVGS: (a+b+1)>>1 computed at element width +1; no overflow.
  - SL: a << (b mod element bits).
  - Saturating ops clamp to the element range. Any clamped element in an accepted op sets the per-op sat flag.
- Reserved esz or op: result forced to zero, sat flag 0, cr6 unaffected. No error output.
- Pipeline:
  - S1 registers op, esz, rc, and per-lane results plus per-lane sat/true/false flags.
  - S2 is the output register.
  - Latency is 2 cycles from acceptance (in_valid & in_ready) to out_valid with no back-pressure.
  - Throughput is 1 op/cycle.
- Handshake:
  - stall = out_valid & ~out_ready. in_ready = ~stall.
  - While stall is asserted, S1 and S2 hold all contents and vrt is stable.
  - in_valid may drop without acceptance. Bubbles propagate as invalid.
- sat update:
  - sat is set when an op carrying its sat flag transfers from S1 to S2, i.e. at the same edge as its result lands in vrt.
  - clr_sat clears it. If clr_sat and a set occur in the same cycle, the set wins (the newer op's saturation is retained).
  - sat is never cleared by anything else except reset.
- cr6 update:
  - Updated only when a compare op with rc=1 moves into S2.
  - all_true = every element true; all_false = every element false.
  - Otherwise cr6 holds its previous value.
- Reset mid-operation: all in-flight ops are discarded. No partial sat/cr6 update.

Decomposition:
- Shared package vsfx_pkg holds:
  - Op code constants and esz constants.
  - A cr6 bit-position constant.
  - The reserved-code check function.
- Natural sub-module: vsfx_lane.
  - Handles one 32-bit lane for all ops and element sizes combinationally.
  - Produces result[31:0], sat, any_false, any_true.
  - Instantiated LANES times via generate.
- vsfx_pipe contains only the pipeline registers, handshake, sticky sat and cr6 logic.

Test Plan:
- ADDSS, esz=2, vra lanes 0x7FFFFFFF, vrb lanes 0x00000001, out_ready=1 -> vrt all lanes 0x7FFFFFFF, out_valid exactly 2 cycles after accept, sat=1 coincident with out_valid; then clr_sat pulse -> sat=0.
- ADDM, esz=0, vra=0xFF repeated, vrb=0x01 repeated -> vrt=0x00 repeated, sat stays 0; same operands with ADDUS -> vrt=0xFF repeated, sat=1.
- CMPEQ, rc=1, esz=1, vra=vrb=0x1234 repeated -> vrt all ones, cr6=4'b1000; then vrb=0x0000 repeated -> vrt=0, cr6=4'b0010; then a mixed-element case -> cr6=4'b0000.
- Back-pressure: issue 4 back-to-back ADDM ops with out_ready held low for 3 cycles from the first out_valid -> in_ready=0 during the stall, vrt stable, all 4 results delivered in order with no loss or duplication.
- AVGS, esz=1, vra=0x8000 repeated, vrb=0xFFFF repeated -> 0xC000 repeated. SL, esz=0, vra=0x81, vrb=0x09 -> 0x02.
- Assert rst_n low while 2 ops are in flight -> out_valid=0, sat=0, cr6=0 immediately (asynchronously). No stale result appears after release.
